// File: rtl/debug_tx_sender.sv
// Streams PC, register file and data memory to a UART transmitter, LSB byte first.
// Optional trailing XOR checksum byte when DEBUG_TX_CHECKSUM_EN is defined.
module debug_tx_sender #(
  parameter int unsigned NB_DATA     = 32,
  parameter int unsigned NB_BYTE     = 8,
  parameter int unsigned N_REGS      = 32,
  parameter int unsigned NB_REG_ADDR = 5,
  parameter int unsigned N_MEM_WORDS = 128,
  parameter int unsigned NB_MEM_ADDR = 7
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   i_start,
  input  logic [NB_DATA-1:0]     i_pc,
  output logic [NB_REG_ADDR-1:0] o_reg_addr,
  input  logic [NB_DATA-1:0]     i_reg_data,
  output logic [NB_MEM_ADDR-1:0] o_mem_addr,
  input  logic [NB_DATA-1:0]     i_mem_data,
  output logic [NB_BYTE-1:0]     o_tx_data,
  output logic                   o_tx_start,
  input  logic                   i_tx_done,
  output logic                   o_busy,
  output logic                   o_finish_send
);

  localparam int unsigned TOTAL       = 1 + N_REGS + N_MEM_WORDS;
  localparam int unsigned NB_WORD_IDX = $clog2(TOTAL);
  localparam int unsigned BYTES       = NB_DATA / NB_BYTE;
  localparam int unsigned NB_BYTE_IDX = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [NB_WORD_IDX-1:0] LAST_WORD     = NB_WORD_IDX'(TOTAL - 1);
  localparam logic [NB_WORD_IDX-1:0] LAST_REG_WORD = NB_WORD_IDX'(N_REGS);
  localparam logic [NB_BYTE_IDX-1:0] LAST_BYTE     = NB_BYTE_IDX'(BYTES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLatch,
    StSend,
    StWaitTx,
`ifdef DEBUG_TX_CHECKSUM_EN
    StCksum,
`endif
    StFinish
  } state_t;

  state_t                 state;
  logic [NB_WORD_IDX-1:0] word_idx;
  logic [NB_BYTE_IDX-1:0] byte_idx;
  logic [NB_DATA-1:0]     shift;
`ifdef DEBUG_TX_CHECKSUM_EN
  logic [NB_BYTE-1:0]     cksum;
  logic                   cksum_phase;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= StIdle;
      word_idx      <= '0;
      byte_idx      <= '0;
      shift         <= '0;
      o_reg_addr    <= '0;
      o_mem_addr    <= '0;
      o_tx_data     <= '0;
      o_tx_start    <= 1'b0;
      o_busy        <= 1'b0;
      o_finish_send <= 1'b0;
`ifdef DEBUG_TX_CHECKSUM_EN
      cksum         <= '0;
      cksum_phase   <= 1'b0;
`endif
    end else begin
      o_tx_start    <= 1'b0;
      o_finish_send <= 1'b0;
      case (state)
        StIdle: begin
          o_busy <= i_start;
          if (i_start) begin
            word_idx <= '0;
            state    <= StFetch;
`ifdef DEBUG_TX_CHECKSUM_EN
            cksum       <= '0;
            cksum_phase <= 1'b0;
`endif
          end
        end
        // Address was already presented on entry, so sync sources capture it at this edge.
        StFetch: state <= StLatch;
        StLatch: begin
          if (word_idx == '0) begin
            shift <= i_pc;
          end else if (word_idx <= LAST_REG_WORD) begin
            shift <= i_reg_data;
          end else begin
            shift <= i_mem_data;
          end
          byte_idx <= '0;
          state    <= StSend;
        end
        StSend: begin
          o_tx_data  <= shift[NB_BYTE-1:0];
          o_tx_start <= 1'b1;
`ifdef DEBUG_TX_CHECKSUM_EN
          cksum <= cksum ^ shift[NB_BYTE-1:0];
`endif
          state <= StWaitTx;
        end
        StWaitTx: begin
          // A done coincident with our own strobe cannot belong to this byte.
          if (i_tx_done && !o_tx_start) begin
`ifdef DEBUG_TX_CHECKSUM_EN
            if (cksum_phase) begin
              state <= StFinish;
            end else
`endif
            if (byte_idx != LAST_BYTE) begin
              shift    <= shift >> NB_BYTE;
              byte_idx <= byte_idx + 1'b1;
              state    <= StSend;
            end else if (word_idx == LAST_WORD) begin
`ifdef DEBUG_TX_CHECKSUM_EN
              state <= StCksum;
`else
              state <= StFinish;
`endif
            end else begin
              word_idx <= word_idx + 1'b1;
              if (word_idx < LAST_REG_WORD) begin
                o_reg_addr <= NB_REG_ADDR'(word_idx);
              end else begin
                o_mem_addr <= NB_MEM_ADDR'(word_idx - LAST_REG_WORD);
              end
              state <= StFetch;
            end
          end
        end
`ifdef DEBUG_TX_CHECKSUM_EN
        StCksum: begin
          shift       <= NB_DATA'(cksum);
          cksum_phase <= 1'b1;
          state       <= StSend;
        end
`endif
        StFinish: begin
          o_finish_send <= 1'b1;
          state         <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
